// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared constants, typedefs and counter helper for the branch history table
package bp_pkg;

    localparam int DEF_IDX_W = 6;
    localparam int DEF_CTR_W = 2;
    localparam int DEF_GHR_W = 6;

    typedef logic [DEF_CTR_W-1:0] ctr_t;
    typedef logic [DEF_IDX_W-1:0] idx_t;

    // Counters are at most 4 bits wide; callers zero-extend and truncate around this.
    function automatic logic [3:0] sat_update(
        input logic [3:0] ctr,
        input logic [3:0] ctr_max,
        input logic       taken
    );
        if (taken) begin
            return (ctr == ctr_max) ? ctr : ctr + 4'd1;
        end
        return (ctr == 4'd0) ? ctr : ctr - 4'd1;
    endfunction

endpackage

// File: rtl/bp_ctr_table.sv
// rtl/bp_ctr_table.sv - saturating counter array, combinational read, one synchronous write
module bp_ctr_table
    import bp_pkg::*;
#(
    parameter int IDX_W    = DEF_IDX_W,
    parameter int CTR_W    = DEF_CTR_W,
    parameter int INIT_CTR = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [CTR_W-1:0] rd_ctr,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_taken
);

    localparam int          DEPTH    = 1 << IDX_W;
    localparam logic [3:0]  CTR_MAX  = 4'((1 << CTR_W) - 1);

    logic [CTR_W-1:0] mem [DEPTH];

    // Read returns the pre-write value when rd_idx == wr_idx: no bypass.
    assign rd_ctr = mem[rd_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= CTR_W'(INIT_CTR);
            end
        end else if (wr_en) begin
            mem[wr_idx] <= CTR_W'(sat_update(4'(mem[wr_idx]), CTR_MAX, wr_taken));
        end
    end

endmodule

// File: rtl/branch_predictor_bht.sv
// rtl/branch_predictor_bht.sv - PC-indexed BHT with statistics; BRANCH_PREDICTOR_GSHARE_EN adds global history hashing
module branch_predictor_bht
    import bp_pkg::*;
#(
    parameter int IDX_W    = DEF_IDX_W,
    parameter int CTR_W    = DEF_CTR_W,
    parameter int INIT_CTR = 1,
    parameter int GHR_W    = DEF_GHR_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             lookup_valid_i,
    input  logic [31:0]      lookup_pc_i,
    output logic             predict_o,
    output logic [IDX_W-1:0] lookup_idx_o,
    output logic [GHR_W-1:0] lookup_ghr_o,
    input  logic             update_valid_i,
    input  logic [IDX_W-1:0] update_idx_i,
    input  logic [GHR_W-1:0] update_ghr_i,
    input  logic             update_taken_i,
    input  logic             update_mispredict_i,
    output logic [31:0]      branch_cnt_o,
    output logic [31:0]      mispredict_cnt_o
);

    logic [IDX_W-1:0] base_idx;
    logic [CTR_W-1:0] rd_ctr;
    logic             mispredict;

    assign base_idx   = lookup_pc_i[IDX_W+1:2];
    assign predict_o  = rd_ctr[CTR_W-1];
    // Gating with valid keeps an undriven mispredict flag out of state.
    assign mispredict = update_valid_i && update_mispredict_i;

`ifdef BRANCH_PREDICTOR_GSHARE_EN
    logic [GHR_W-1:0] ghr;
    logic             unused_pc;

    assign lookup_idx_o = base_idx ^ IDX_W'(ghr);
    assign lookup_ghr_o = ghr;
    assign unused_pc    = ^{lookup_pc_i[31:IDX_W+2], lookup_pc_i[1:0]};

    // Recovery wins: a lookup in the same cycle is on the flushed wrong path.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ghr <= '0;
        end else if (mispredict) begin
            ghr <= GHR_W'({update_ghr_i, update_taken_i});
        end else if (lookup_valid_i) begin
            ghr <= GHR_W'({ghr, predict_o});
        end
    end
`else
    logic unused_in;

    assign lookup_idx_o = base_idx;
    assign lookup_ghr_o = '0;
    assign unused_in    = ^{lookup_pc_i[31:IDX_W+2], lookup_pc_i[1:0], update_ghr_i, lookup_valid_i};
`endif

    bp_ctr_table #(
        .IDX_W    (IDX_W),
        .CTR_W    (CTR_W),
        .INIT_CTR (INIT_CTR)
    ) u_table (
        .clk      (clk_i),
        .rst      (rst_i),
        .rd_idx   (lookup_idx_o),
        .rd_ctr   (rd_ctr),
        .wr_en    (update_valid_i),
        .wr_idx   (update_idx_i),
        .wr_taken (update_taken_i)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            branch_cnt_o     <= '0;
            mispredict_cnt_o <= '0;
        end else begin
            if (update_valid_i && branch_cnt_o != 32'hFFFF_FFFF) begin
                branch_cnt_o <= branch_cnt_o + 32'd1;
            end
            if (mispredict && mispredict_cnt_o != 32'hFFFF_FFFF) begin
                mispredict_cnt_o <= mispredict_cnt_o + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor_bht.sv
// tb/tb_branch_predictor_bht.sv - randomized and directed bench for branch_predictor_bht
module tb_branch_predictor_bht;

    localparam int IDX_W = 6;
    localparam int GHR_W = 6;
    localparam int NENT  = 64;
    localparam int CMAX  = 3;
`ifdef BRANCH_PREDICTOR_GSHARE_EN
    localparam bit GSHARE = 1'b1;
`else
    localparam bit GSHARE = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_i;
    logic             lookup_valid_i;
    logic [31:0]      lookup_pc_i;
    logic             predict_o;
    logic [IDX_W-1:0] lookup_idx_o;
    logic [GHR_W-1:0] lookup_ghr_o;
    logic             update_valid_i;
    logic [IDX_W-1:0] update_idx_i;
    logic [GHR_W-1:0] update_ghr_i;
    logic             update_taken_i;
    logic             update_mispredict_i;
    logic [31:0]      branch_cnt_o;
    logic [31:0]      mispredict_cnt_o;

    int checks = 0;
    int errors = 0;

    int m_ctr [NENT];
    int m_ghr;
    int m_bc;
    int m_mc;

    always #5 clk = ~clk;

    branch_predictor_bht dut (
        .clk_i               (clk),
        .rst_i               (rst_i),
        .lookup_valid_i      (lookup_valid_i),
        .lookup_pc_i         (lookup_pc_i),
        .predict_o           (predict_o),
        .lookup_idx_o        (lookup_idx_o),
        .lookup_ghr_o        (lookup_ghr_o),
        .update_valid_i      (update_valid_i),
        .update_idx_i        (update_idx_i),
        .update_ghr_i        (update_ghr_i),
        .update_taken_i      (update_taken_i),
        .update_mispredict_i (update_mispredict_i),
        .branch_cnt_o        (branch_cnt_o),
        .mispredict_cnt_o    (mispredict_cnt_o)
    );

    function automatic void m_reset();
        for (int i = 0; i < NENT; i++) m_ctr[i] = 1;
        m_ghr = 0;
        m_bc  = 0;
        m_mc  = 0;
    endfunction

    function automatic int m_idx(input logic [31:0] pc);
        return ((int'(pc) >>> 2) & (NENT - 1)) ^ (GSHARE ? m_ghr : 0);
    endfunction

    function automatic bit m_pred(input logic [31:0] pc);
        return m_ctr[m_idx(pc)] >= 2;
    endfunction

    // Applies one clock edge of the reference behaviour using the currently driven inputs.
    function automatic void m_edge();
        bit pred;
        pred = m_pred(lookup_pc_i);
        if (update_valid_i) begin
            if (update_taken_i) m_ctr[update_idx_i] = (m_ctr[update_idx_i] < CMAX) ? m_ctr[update_idx_i] + 1 : CMAX;
            else                m_ctr[update_idx_i] = (m_ctr[update_idx_i] > 0) ? m_ctr[update_idx_i] - 1 : 0;
            m_bc++;
            if (update_mispredict_i) m_mc++;
        end
        if (GSHARE) begin
            if (update_valid_i && update_mispredict_i)
                m_ghr = ((int'(update_ghr_i) << 1) | int'(update_taken_i)) & ((1 << GHR_W) - 1);
            else if (lookup_valid_i)
                m_ghr = ((m_ghr << 1) | int'(pred)) & ((1 << GHR_W) - 1);
        end
    endfunction

    task automatic idle();
        lookup_valid_i      = 1'b0;
        update_valid_i      = 1'b0;
        update_idx_i        = '0;
        update_ghr_i        = '0;
        update_taken_i      = 1'bx;
        update_mispredict_i = 1'bx;
    endtask

    task automatic tick();
        m_edge();
        @(posedge clk);
        @(negedge clk);
        #2;
    endtask

    task automatic upd(input int idx, input bit taken);
        update_valid_i      = 1'b1;
        update_idx_i        = IDX_W'(idx);
        update_taken_i      = taken;
        update_mispredict_i = 1'b0;
        tick();
        idle();
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        idle();
        lookup_pc_i = 32'h100;
        m_reset();
        repeat (2) @(negedge clk);
        rst_i = 1'b0;
        #2;
        if (predict_o !== 1'b0) begin errors++; $display("FAIL reset_predict got %0b exp 0", predict_o); end
        checks++;
        if (lookup_idx_o !== 6'd0) begin errors++; $display("FAIL reset_idx got %0d exp 0", lookup_idx_o); end
        checks++;
        if (branch_cnt_o !== 32'd0 || mispredict_cnt_o !== 32'd0) begin
            errors++; $display("FAIL reset_stats got %0d/%0d exp 0/0", branch_cnt_o, mispredict_cnt_o);
        end
        checks++;
    endtask

    task automatic test_saturation();
        bit seq [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        lookup_pc_i = 32'h40;
        for (int i = 0; i < 5; i++) begin
            upd(16, seq[i]);
            if (predict_o !== m_pred(lookup_pc_i)) begin
                errors++; $display("FAIL sat_step%0d got %0b exp %0b", i, predict_o, m_pred(lookup_pc_i));
            end
            checks++;
        end
        if (branch_cnt_o !== 32'(m_bc)) begin errors++; $display("FAIL sat_branch_cnt got %0d exp %0d", branch_cnt_o, m_bc); end
        checks++;
    endtask

    task automatic test_alias();
        lookup_pc_i = 32'h140;
        upd(16, 1'b1);
        if (lookup_idx_o !== 6'd16) begin errors++; $display("FAIL alias_idx got %0d exp 16", lookup_idx_o); end
        checks++;
        if (predict_o !== 1'b1) begin errors++; $display("FAIL alias_predict got %0b exp 1", predict_o); end
        checks++;
    endtask

    task automatic test_same_cycle();
        lookup_pc_i         = 32'h14;
        update_valid_i      = 1'b1;
        update_idx_i        = 6'd5;
        update_taken_i      = 1'b1;
        update_mispredict_i = 1'b0;
        #1;
        if (predict_o !== 1'b0) begin errors++; $display("FAIL hazard_same got %0b exp 0", predict_o); end
        checks++;
        tick();
        idle();
        if (predict_o !== 1'b1) begin errors++; $display("FAIL hazard_next got %0b exp 1", predict_o); end
        checks++;
    endtask

    task automatic test_async_reset();
        lookup_pc_i = 32'h40;
        repeat (3) upd(16, 1'b1);
        rst_i = 1'b1;
        m_reset();
        #1;
        if (predict_o !== 1'b0 || branch_cnt_o !== 32'd0 || mispredict_cnt_o !== 32'd0 || lookup_ghr_o !== 6'd0) begin
            errors++; $display("FAIL async_reset got pred %0b bc %0d mc %0d ghr %0d exp 0", predict_o, branch_cnt_o, mispredict_cnt_o, lookup_ghr_o);
        end
        checks++;
        @(negedge clk);
        rst_i = 1'b0;
        #2;
        upd(16, 1'b1);
        if (predict_o !== 1'b1 || branch_cnt_o !== 32'd1) begin
            errors++; $display("FAIL async_resume got pred %0b bc %0d exp 1/1", predict_o, branch_cnt_o);
        end
        checks++;
    endtask

    task automatic test_random();
        int bad = 0;
        for (int n = 0; n < 300; n++) begin
            lookup_pc_i    = {$urandom_range(0, 255), 22'h0, 6'($urandom_range(0, 7)) , 2'($urandom_range(0, 3))};
            lookup_valid_i = 1'($urandom_range(0, 1));
            update_valid_i = ($urandom_range(0, 3) != 0);
            update_idx_i   = IDX_W'($urandom_range(0, 7));
            update_ghr_i   = GHR_W'($urandom);
            if (update_valid_i) begin
                update_taken_i      = 1'($urandom_range(0, 1));
                update_mispredict_i = ($urandom_range(0, 4) == 0);
            end else begin
                update_taken_i      = 1'bx;
                update_mispredict_i = 1'bx;
            end
            #1;
            if (predict_o !== m_pred(lookup_pc_i) || lookup_idx_o !== IDX_W'(m_idx(lookup_pc_i)) ||
                lookup_ghr_o !== GHR_W'(GSHARE ? m_ghr : 0) ||
                branch_cnt_o !== 32'(m_bc) || mispredict_cnt_o !== 32'(m_mc)) begin
                if (bad < 5) $display("FAIL random_%0d got pred %0b idx %0d ghr %0d bc %0d mc %0d exp %0b %0d %0d %0d %0d",
                    n, predict_o, lookup_idx_o, lookup_ghr_o, branch_cnt_o, mispredict_cnt_o,
                    m_pred(lookup_pc_i), m_idx(lookup_pc_i), GSHARE ? m_ghr : 0, m_bc, m_mc);
                bad++;
                errors++;
            end
            checks++;
            tick();
        end
        idle();
    endtask

`ifdef BRANCH_PREDICTOR_GSHARE_EN
    task automatic test_gshare();
        int mc0;
        rst_i = 1'b1;
        m_reset();
        @(negedge clk);
        rst_i = 1'b0;
        #2;
        lookup_pc_i = 32'h40;
        upd(16, 1'b1);
        upd(16, 1'b1);
        lookup_valid_i = 1'b1;
        tick();
        if (lookup_ghr_o !== 6'b000001) begin errors++; $display("FAIL gshare_shift got %b exp 000001", lookup_ghr_o); end
        checks++;
        mc0 = m_mc;
        update_valid_i      = 1'b1;
        update_idx_i        = 6'd3;
        update_ghr_i        = 6'b000101;
        update_taken_i      = 1'b1;
        update_mispredict_i = 1'b1;
        tick();
        idle();
        if (lookup_ghr_o !== 6'b001011) begin errors++; $display("FAIL gshare_recover got %b exp 001011", lookup_ghr_o); end
        checks++;
        if (mispredict_cnt_o !== 32'(mc0 + 1)) begin errors++; $display("FAIL gshare_mcnt got %0d exp %0d", mispredict_cnt_o, mc0 + 1); end
        checks++;
    endtask
`endif

    initial begin
        test_reset();
        test_saturation();
        test_alias();
        test_same_cycle();
        test_async_reset();
        test_random();
`ifdef BRANCH_PREDICTOR_GSHARE_EN
        test_gshare();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_predictor_bht.md
Name: branch_predictor_bht

Overview:
Parametrised successor to the single 2-bit branch predictor. Holds a PC-indexed table of saturating counters (branch history table), looked up in ID and updated when the branch resolves in EX. The lookup index travels down the pipeline, so each update hits the same entry that made the prediction. Also keeps branch and misprediction statistics for the testbench.

Parameters:
IDX_W, 6, index width; table has 2**IDX_W entries
CTR_W, 2, counter width; 1 to 4
INIT_CTR, 1, counter reset value (weakly not-taken); must be less than 2**CTR_W
GHR_W, 6, global history width; 1 to IDX_W (used only with GSHARE_EN)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
lookup_valid_i  in  1  ID holds a branch and is not stalled
lookup_pc_i  in  32  PC of the ID-stage branch
predict_o  out  1  predicted taken
lookup_idx_o  out  IDX_W  table index used by this lookup; carried to EX
lookup_ghr_o  out  GHR_W  history snapshot at lookup; carried to EX
update_valid_i  in  1  a branch resolved in EX this cycle
update_idx_i  in  IDX_W  index carried with that branch
update_ghr_i  in  GHR_W  history snapshot carried with that branch
update_taken_i  in  1  actual outcome
update_mispredict_i  in  1  actual outcome differed from the prediction
branch_cnt_o  out  32  number of resolved branches
mispredict_cnt_o  out  32  number of mispredictions

Behaviour:
- Reset (asynchronous, takes effect immediately, no clock edge needed):
  - all counters = INIT_CTR
  - GHR = 0
  - branch_cnt_o = 0, mispredict_cnt_o = 0
- Base index: lookup_pc_i[IDX_W+1:2] (word-aligned PCs). Aliasing is allowed.
- Lookup is combinational, zero latency:
  - lookup_idx_o is the index.
  - predict_o = MSB of that counter.
  - Outputs are valid even when lookup_valid_i = 0.
- Update happens on the rising edge when update_valid_i = 1:
  - taken: counter = min(counter + 1, 2**CTR_W - 1)
  - not-taken: counter = max(counter - 1, 0)
  - Arithmetic is CTR_W wide; the counter never wraps.
- Same cycle, same index for lookup and update: predict_o shows the pre-update value (no bypass). The new value is visible from the next cycle.
- Statistics counters, updated on the edge:
  - branch_cnt_o += 1 when update_valid_i = 1.
  - mispredict_cnt_o += 1 when update_valid_i and update_mispredict_i are both 1.
  - Both saturate at 32'hFFFF_FFFF.
- update_mispredict_i is ignored when update_valid_i = 0.
- With update_valid_i = 0, the table and statistics hold.
- update_taken_i and update_mispredict_i may be sampled as X when not valid; the design must not propagate X into state.

Optional Feature:
BRANCH_PREDICTOR_GSHARE_EN
- Defined:
  - Index = base index XOR zero-extended GHR.
  - Speculative shift: on lookup_valid_i, GHR <= {GHR[GHR_W-2:0], predict_o}.
  - Recovery: on update_valid_i with update_mispredict_i, GHR <= {update_ghr_i[GHR_W-2:0], update_taken_i}.
  - Recovery has priority over a same-cycle lookup shift, because that lookup is on the flushed wrong path.
  - lookup_ghr_o = current GHR.
- Undefined:
  - Index = base index only.
  - No GHR storage; lookup_ghr_o is driven 0.
  - update_ghr_i is ignored.

Decomposition:
- Package bp_pkg:
  - constants for default IDX_W, CTR_W, GHR_W
  - ctr_t / idx_t typedefs
  - function sat_update(ctr, taken)
- One sub-module, bp_ctr_table:
  - counter array with async reset to INIT_CTR
  - combinational read port and one synchronous write port
- Top level holds index hashing, the GHR and the statistics.

Test Plan:
All scenarios use default parameters.
1. Reset: release rst_i, lookup PC 0x100 -> predict_o = 0, lookup_idx_o = 6'd0, both statistics = 0.
2. Saturation, at idx 16 (PC 0x40):
   - 3 taken updates -> counter 2, 3, 3; predict_o = 1 after the first.
   - Then 2 not-taken -> counter 2, 1; predict_o = 0 after the second.
   - branch_cnt_o = 5.
3. Aliasing: PC 0x140 also maps to idx 16. Taken updates via 0x40 -> lookup of 0x140 predicts 1.
4. Same-cycle hazard: lookup and taken update on idx 5 with counter 1 -> predict_o = 0 that cycle, 1 the next cycle.
5. Async reset mid-update: assert rst_i between edges after 3 taken updates -> counters, statistics and GHR return to reset values immediately; later updates resume normally.
6. GSHARE_EN: GHR 6'b000000 with lookup predicting taken -> GHR 6'b000001. In the same cycle as another lookup, mispredict with update_ghr_i = 6'b000101, taken = 1 -> GHR 6'b001011, and mispredict_cnt_o increments.
